spi_pwm_config: RTL and testbench

Mode-0 SPI target that receives 16-bit write frames from an off-chip host and loads the five configuration registers driving the PWM peripheral. These are output-enable low and high, PWM-enable low and high, and duty cycle. It sits in the top level between the uio/ui input pins and pwm_peripheral. It owns all PWM configuration state. SCLK, nCS and COPI are asynchronous to clk and are resynchronised internally.

---
 rtl/spi_pwm_config_if.sv | 9 +
 rtl/spi_pwm_config.sv | 146 ++++++++++++++
 tb/tb_spi_pwm_config.sv | 175 +++++++++++++++++
 3 files changed

// File: rtl/spi_pwm_config_if.sv
// SPI pin bundle between an off-chip host and the PWM configuration target.
interface spi_pwm_config_if;
  logic ncs;
  logic sclk;
  logic copi;

  modport master (output ncs, output sclk, output copi);
  modport slave  (input ncs, input sclk, input copi);
endinterface

// File: rtl/spi_pwm_config.sv
// Mode-0 SPI write-only target loading the five PWM configuration registers.
// SPI pins are resynchronised into clk; frames are 16 bits, MSB first.
module spi_pwm_config #(
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned MAX_ADDR    = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  spi_pwm_config_if.slave       spi,
  output logic [7:0]            en_reg_out_7_0,
  output logic [7:0]            en_reg_out_15_8,
  output logic [7:0]            en_reg_pwm_7_0,
  output logic [7:0]            en_reg_pwm_15_8,
  output logic [7:0]            pwm_duty_cycle,
  output logic                  wr_strobe,
  output logic                  frame_err
);

  localparam int unsigned FRAME_W = 16;
  localparam int unsigned CNT_W   = 5;
  localparam int unsigned ADDR_W  = 7;
  localparam logic [ADDR_W-1:0] MAX_A = ADDR_W'(MAX_ADDR);

  typedef enum logic [1:0] {IDLE, SHIFT, COMMIT} state_t;

  logic [SYNC_STAGES-1:0] ncs_sync, sclk_sync, copi_sync;
  logic                   ncs_s, sclk_s, copi_s;
  logic                   ncs_d, sclk_d;
  logic                   ncs_fall, ncs_rise, sclk_rise;

  state_t              state, state_next;
  logic [CNT_W-1:0]    bit_cnt;
  logic [FRAME_W-1:0]  shift;
  logic                overflow;

  logic                frame_ok_c;
  logic [ADDR_W-1:0]   addr_c;
  logic [7:0]          data_c;
  logic                wr_c, err_c;

  assign ncs_s  = ncs_sync[SYNC_STAGES-1];
  assign sclk_s = sclk_sync[SYNC_STAGES-1];
  assign copi_s = copi_sync[SYNC_STAGES-1];

  assign ncs_fall  = ncs_d & ~ncs_s;
  assign ncs_rise  = ~ncs_d & ncs_s;
  assign sclk_rise = ~sclk_d & sclk_s;

  assign frame_ok_c = (bit_cnt == CNT_W'(FRAME_W)) && !overflow;
  assign addr_c     = shift[14:8];
  assign data_c     = shift[7:0];

  // Input synchronisers plus one-cycle-delayed copies for edge detection
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ncs_sync  <= '1;
      sclk_sync <= '0;
      copi_sync <= '0;
      ncs_d     <= 1'b1;
      sclk_d    <= 1'b0;
    end else begin
      ncs_sync  <= {ncs_sync[SYNC_STAGES-2:0], spi.ncs};
      sclk_sync <= {sclk_sync[SYNC_STAGES-2:0], spi.sclk};
      copi_sync <= {copi_sync[SYNC_STAGES-2:0], spi.copi};
      ncs_d     <= ncs_s;
      sclk_d    <= sclk_s;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (ncs_fall) state_next = SHIFT;
      SHIFT:   if (ncs_rise) state_next = frame_ok_c ? COMMIT : IDLE;
      COMMIT:  state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Write/error decisions; read frames (bit15 = 0) fall through silently
  always_comb begin
    wr_c  = 1'b0;
    err_c = 1'b0;
    case (state)
      SHIFT: if (ncs_rise && !frame_ok_c) err_c = 1'b1;
      COMMIT: begin
        if (shift[15]) begin
          if (addr_c <= MAX_A) wr_c  = 1'b1;
          else                 err_c = 1'b1;
        end
      end
      default: ;
    endcase
  end

  // Frame shifter; bits past the 16th only flag overflow
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      bit_cnt  <= '0;
      shift    <= '0;
      overflow <= 1'b0;
    end else if (state == IDLE && ncs_fall) begin
      bit_cnt  <= '0;
      shift    <= '0;
      overflow <= 1'b0;
    end else if (state == SHIFT && sclk_rise && !ncs_s) begin
      if (bit_cnt == CNT_W'(FRAME_W)) begin
        overflow <= 1'b1;
      end else begin
        shift   <= {shift[FRAME_W-2:0], copi_s};
        bit_cnt <= bit_cnt + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      en_reg_out_7_0  <= '0;
      en_reg_out_15_8 <= '0;
      en_reg_pwm_7_0  <= '0;
      en_reg_pwm_15_8 <= '0;
      pwm_duty_cycle  <= '0;
      wr_strobe       <= 1'b0;
      frame_err       <= 1'b0;
    end else begin
      wr_strobe <= wr_c;
      frame_err <= err_c;
      if (wr_c) begin
        case (addr_c)
          7'd0:    en_reg_out_7_0  <= data_c;
          7'd1:    en_reg_out_15_8 <= data_c;
          7'd2:    en_reg_pwm_7_0  <= data_c;
          7'd3:    en_reg_pwm_15_8 <= data_c;
          7'd4:    pwm_duty_cycle  <= data_c;
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_spi_pwm_config.sv
// Directed bench for spi_pwm_config: frames driven bit-by-bit, expectations hand-computed.
module tb_spi_pwm_config;

  localparam int SYNC = 2;
  localparam int WATCH = 12;

  logic clk = 1'b0;
  logic rst_n;
  logic [7:0] en_reg_out_7_0, en_reg_out_15_8, en_reg_pwm_7_0, en_reg_pwm_15_8, pwm_duty_cycle;
  logic wr_strobe, frame_err;

  int tests = 0;
  int fails = 0;

  int strobes, errs, strobe_cyc;
  logic [7:0] snap [1:WATCH];

  spi_pwm_config_if spi ();

  spi_pwm_config #(.SYNC_STAGES(SYNC), .MAX_ADDR(4)) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .spi             (spi),
    .en_reg_out_7_0  (en_reg_out_7_0),
    .en_reg_out_15_8 (en_reg_out_15_8),
    .en_reg_pwm_7_0  (en_reg_pwm_7_0),
    .en_reg_pwm_15_8 (en_reg_pwm_15_8),
    .pwm_duty_cycle  (pwm_duty_cycle),
    .wr_strobe       (wr_strobe),
    .frame_err       (frame_err)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic cs_low();
    cyc(1);
    spi.ncs = 1'b0;
    cyc(4);
  endtask

  // sclk half period of four clk cycles keeps well inside the 4x ratio
  task automatic shift_bits(input logic [31:0] bits, input int n);
    for (int i = n - 1; i >= 0; i--) begin
      spi.copi = bits[i];
      cyc(4);
      spi.sclk = 1'b1;
      cyc(4);
      spi.sclk = 1'b0;
    end
    cyc(4);
  endtask

  task automatic cs_high_watch();
    strobes    = 0;
    errs       = 0;
    strobe_cyc = 0;
    cyc(1);
    spi.ncs = 1'b1;
    for (int k = 1; k <= WATCH; k++) begin
      cyc(1);
      snap[k] = en_reg_out_7_0;
      if (wr_strobe) begin
        strobes++;
        strobe_cyc = k;
      end
      if (frame_err) errs++;
    end
  endtask

  task automatic frame(input logic [31:0] bits, input int n);
    cs_low();
    shift_bits(bits, n);
    cs_high_watch();
  endtask

  task automatic check_regs(input string tag, input logic [39:0] exp);
    check({tag, ".out_7_0"},  32'(en_reg_out_7_0),  32'(exp[39:32]));
    check({tag, ".out_15_8"}, 32'(en_reg_out_15_8), 32'(exp[31:24]));
    check({tag, ".pwm_7_0"},  32'(en_reg_pwm_7_0),  32'(exp[23:16]));
    check({tag, ".pwm_15_8"}, 32'(en_reg_pwm_15_8), 32'(exp[15:8]));
    check({tag, ".duty"},     32'(pwm_duty_cycle),  32'(exp[7:0]));
  endtask

  initial begin
    rst_n    = 1'b0;
    spi.ncs  = 1'b1;
    spi.sclk = 1'b0;
    spi.copi = 1'b0;

    // 1: reset with nCS high, then quiet outputs
    cyc(3);
    rst_n = 1'b1;
    check_regs("reset", 40'h00_00_00_00_00);
    strobes = 0;
    errs = 0;
    for (int k = 0; k < 20; k++) begin
      cyc(1);
      if (wr_strobe) strobes++;
      if (frame_err) errs++;
    end
    check("reset.strobes", 32'(strobes), 32'd0);
    check("reset.errs", 32'(errs), 32'd0);

    // 2: first write and its latency from the nCS pin rising
    frame(32'h80F0, 16);
    check("lat.before", 32'(snap[SYNC+1]), 32'h00);
    check("lat.at", 32'(snap[SYNC+2]), 32'hF0);
    check("lat.strobe_cyc", 32'(strobe_cyc), 32'(SYNC + 2));
    check("w0.strobes", 32'(strobes), 32'd1);
    check("w0.errs", 32'(errs), 32'd0);
    check_regs("w0", 40'hF0_00_00_00_00);

    // 3: remaining registers
    frame(32'h81AA, 16); check("w1.strobes", 32'(strobes), 32'd1);
    frame(32'h8255, 16); check("w2.strobes", 32'(strobes), 32'd1);
    frame(32'h83C3, 16); check("w3.strobes", 32'(strobes), 32'd1);
    frame(32'h8480, 16); check("w4.strobes", 32'(strobes), 32'd1);
    check_regs("wall", 40'hF0_AA_55_C3_80);

    // 4: read frame is ignored, address 5 is rejected
    frame(32'h00FF, 16);
    check("rd.strobes", 32'(strobes), 32'd0);
    check("rd.errs", 32'(errs), 32'd0);
    check_regs("rd", 40'hF0_AA_55_C3_80);
    frame(32'h8511, 16);
    check("a5.strobes", 32'(strobes), 32'd0);
    check("a5.errs", 32'(errs), 32'd1);
    check_regs("a5", 40'hF0_AA_55_C3_80);

    // 5: short and long frames
    frame(32'h4078, 15);
    check("short.strobes", 32'(strobes), 32'd0);
    check("short.errs", 32'(errs), 32'd1);
    check_regs("short", 40'hF0_AA_55_C3_80);
    frame({15'd0, 16'h8433, 1'b1}, 17);
    check("long.strobes", 32'(strobes), 32'd0);
    check("long.errs", 32'(errs), 32'd1);
    check("long.duty", 32'(pwm_duty_cycle), 32'h80);

    // 6: reset mid-frame with nCS held low, then the tail of the frame
    cs_low();
    shift_bits(32'h84, 8);
    rst_n = 1'b0;
    cyc(3);
    rst_n = 1'b1;
    check_regs("abort.rst", 40'h00_00_00_00_00);
    cyc(4);
    shift_bits(32'hFF, 8);
    cs_high_watch();
    check("abort.strobes", 32'(strobes), 32'd0);
    check("abort.errs", 32'(errs), 32'd1);
    check_regs("abort", 40'h00_00_00_00_00);
    frame(32'h8440, 16);
    check("post.strobes", 32'(strobes), 32'd1);
    check("post.errs", 32'(errs), 32'd0);
    check_regs("post", 40'h00_00_00_00_40);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
